instr_fetch_queue: RTL and testbench

Front-end fetch unit and instruction queue directly upstream of the reorder buffer. It drives instruction-memory reads from a fetch PC, decodes each returned word into a `pci_t`, and buffers up to `size` entries in a circular FIFO. The ROB pops entries with `instr_q_dequeue`. A ROB `flush` redirects fetch to `flush_pc`, and the unit drops any stale in-flight response.

---
 rtl/instr_fetch_queue.sv | 236 +++++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch unit and circular instruction queue feeding the ROB.
// Issues one instruction-memory read at a time from fetch_pc, decodes each
// returned word into a pci_t and buffers up to `size` entries. The ROB pops
// the head with instr_q_dequeue. A flush clears the queue, redirects fetch to
// flush_pc and drops any stale in-flight response.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   instr_mem_read     read request, held until instr_mem_resp
//   instr_mem_address  fetch address, stable while the read is high
//   instr_mem_rdata    instruction word, valid with instr_mem_resp
//   instr_mem_resp     single-cycle response pulse
//   instr_q_dequeue    ROB pops the head this cycle
//   flush, flush_pc    mispredict flush and its redirect target
//   pci                decoded head entry (or the bypassed response when empty)
//   instr_q_empty      count == 0 (registered)
//   instr_q_full       count == size (registered)

package rv32i_types;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        logic [31:0] pc;
        rv32i_opcode opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] immediate;
        logic        br_pred;
        logic [31:0] branch_pc;
    } pci_t;

endpackage

module instr_fetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned      width    = 32,
    parameter int unsigned      size     = 8,
    parameter logic [width-1:0] start_pc = 32'h0000_0060
) (
    input  logic             clk,
    input  logic             rst,
    output logic             instr_mem_read,
    output logic [width-1:0] instr_mem_address,
    input  logic [31:0]      instr_mem_rdata,
    input  logic             instr_mem_resp,
    input  logic             instr_q_dequeue,
    input  logic             flush,
    input  logic [width-1:0] flush_pc,
    output pci_t             pci,
    output logic             instr_q_empty,
    output logic             instr_q_full
);

    localparam int unsigned idx_w = $clog2(size);
    localparam int unsigned cnt_w = idx_w + 1;

    typedef enum logic [1:0] {IDLE, FETCH, STALL, DISCARD} state_t;

    state_t             state, state_next;
    logic [width-1:0]   fetch_pc, fetch_pc_next;

    pci_t               arr [size];
    logic [idx_w-1:0]   front, rear, rear_inc;
    logic [cnt_w-1:0]   count, count_next;

    pci_t               dec;
    logic               accept, bypass, push, pop;

    // Decode one instruction word fetched from pc.
    function automatic pci_t decode(input logic [width-1:0] pc, input logic [31:0] w);
        pci_t        d;
        logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
        imm_i = {{21{w[31]}}, w[30:20]};
        imm_s = {{21{w[31]}}, w[30:25], w[11:7]};
        imm_b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
        imm_u = {w[31:12], 12'h000};
        imm_j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
        d           = '0;
        d.pc        = 32'(pc);
        d.opcode    = rv32i_opcode'(w[6:0]);
        d.rd        = w[11:7];
        d.funct3    = w[14:12];
        d.rs1       = w[19:15];
        d.rs2       = w[24:20];
        d.funct7    = w[31:25];
        d.immediate = imm_i;
        case (d.opcode)
            op_lui, op_auipc: d.immediate = imm_u;
            op_store:         d.immediate = imm_s;
            op_reg:           d.immediate = 32'h0;
            op_br: begin
                d.immediate = imm_b;
                d.branch_pc = d.pc + imm_b;
            end
            op_jal: begin
                d.immediate = imm_j;
                d.br_pred   = 1'b1;
                d.branch_pc = d.pc + imm_j;
            end
            default:          d.immediate = imm_i;
        endcase
        return d;
    endfunction

    // Power-on contents of every queue slot.
    function automatic pci_t cleared_entry();
        pci_t e;
        e        = '0;
        e.opcode = op_imm;
        return e;
    endfunction

    assign dec = decode(fetch_pc, instr_mem_rdata);

    // A response is only kept in FETCH and only when no flush competes with it.
    assign accept   = (state == FETCH) && instr_mem_resp && !flush;
    assign bypass   = accept && (count == '0);
    assign push     = accept && !(bypass && instr_q_dequeue);
    assign pop      = instr_q_dequeue && !flush && (count != '0);
    assign rear_inc = rear + idx_w'(1);

    always_comb begin
        count_next = count + cnt_w'(push) - cnt_w'(pop);
        if (flush) begin
            count_next = '0;
        end
    end

    // Head of queue, or the freshly decoded word when the queue is empty.
    assign pci = bypass ? dec : arr[front];

    // Fetch FSM: next state and next fetch PC.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        unique case (state)
            IDLE: begin
                state_next = FETCH;
                if (flush) begin
                    fetch_pc_next = flush_pc;
                end
            end
            FETCH: begin
                if (flush) begin
                    fetch_pc_next = flush_pc;
                    state_next    = instr_mem_resp ? FETCH : DISCARD;
                end else if (instr_mem_resp) begin
                    fetch_pc_next = (dec.opcode == op_jal) ? width'(dec.branch_pc)
                                                           : fetch_pc + width'(4);
                    state_next    = (count_next == cnt_w'(size)) ? STALL : FETCH;
                end
            end
            STALL: begin
                if (flush) begin
                    fetch_pc_next = flush_pc;
                    state_next    = FETCH;
                end else if (count < cnt_w'(size)) begin
                    state_next = FETCH;
                end
            end
            DISCARD: begin
                if (flush) begin
                    fetch_pc_next = flush_pc;
                end
                if (instr_mem_resp) begin
                    state_next = FETCH;
                end
            end
        endcase
    end

    // FSM state, fetch PC and registered memory request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            fetch_pc          <= start_pc;
            instr_mem_address <= start_pc;
            instr_mem_read    <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            // DISCARD keeps presenting the abandoned address until its response lands.
            if (state_next != DISCARD) begin
                instr_mem_address <= fetch_pc_next;
            end
            instr_mem_read <= (state_next == FETCH) || (state_next == DISCARD);
        end
    end

    // Circular queue storage, pointers and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(size); i++) begin
                arr[i] <= cleared_entry();
            end
            front         <= '0;
            rear          <= idx_w'(size - 1);
            count         <= '0;
            instr_q_empty <= 1'b1;
            instr_q_full  <= 1'b0;
        end else begin
            if (flush) begin
                front <= '0;
                rear  <= idx_w'(size - 1);
            end else begin
                if (push) begin
                    arr[rear_inc] <= dec;
                    rear          <= rear_inc;
                end
                if (pop) begin
                    front <= front + idx_w'(1);
                end
            end
            count         <= count_next;
            instr_q_empty <= (count_next == '0);
            instr_q_full  <= (count_next == cnt_w'(size));
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: a memory model answers requests against a list of
// hand-computed expected fetch addresses; accepted responses go into a scoreboard
// that a monitor pops whenever the ROB side dequeues.
module tb_instr_fetch_queue;
    import rv32i_types::*;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        br_pred;
        logic [31:0] branch_pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        instr_mem_read;
    logic [31:0] instr_mem_address;
    logic [31:0] instr_mem_rdata;
    logic        instr_mem_resp;
    logic        instr_q_dequeue;
    logic        flush;
    logic [31:0] flush_pc;
    pci_t        pci;
    logic        instr_q_empty;
    logic        instr_q_full;

    instr_fetch_queue #(.width(32), .size(8), .start_pc(32'h0000_0060)) dut (
        .clk               (clk),
        .rst               (rst),
        .instr_mem_read    (instr_mem_read),
        .instr_mem_address (instr_mem_address),
        .instr_mem_rdata   (instr_mem_rdata),
        .instr_mem_resp    (instr_mem_resp),
        .instr_q_dequeue   (instr_q_dequeue),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .pci               (pci),
        .instr_q_empty     (instr_q_empty),
        .instr_q_full      (instr_q_full)
    );

    int          n_checks = 0;
    int          n_fail   = 0;

    ent_t        imem [logic [31:0]];
    logic [31:0] exp_addr [$];
    ent_t        exp_q [$];

    int          mem_lat  = 0;
    bit          pending  = 0;
    bit          stale    = 0;
    int          cnt      = 0;
    logic [31:0] req_pc   = '0;
    logic [31:0] req_addr = '0;
    bit          acc_now  = 0;
    ent_t        acc_entry;

    bit          deq_en    = 0;
    bit          deq_force = 0;
    int          deq_keep  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    // Default program: addi x(a[6:2]), x0, a[11:0]
    function automatic ent_t ent_at(input logic [31:0] a);
        ent_t e;
        if (imem.exists(a)) begin
            e = imem[a];
        end else begin
            e.word      = {a[11:0], 5'd0, 3'd0, a[6:2], 7'b0010011};
            e.opcode    = 7'h13;
            e.rd        = a[6:2];
            e.imm       = {{20{a[11]}}, a[11:0]};
            e.br_pred   = 1'b0;
            e.branch_pc = 32'h0;
        end
        e.pc = a;
        return e;
    endfunction

    task automatic push_range(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(start + 32'(4 * i));
        end
    endtask

    // Memory model: registers a request, answers after mem_lat cycles.
    initial begin
        ent_t e;
        instr_mem_resp  = 1'b0;
        instr_mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            instr_mem_resp = 1'b0;
            acc_now        = 1'b0;
            if (rst) begin
                pending = 0;
                stale   = 0;
            end else begin
                if (pending) begin
                    check32("req_read_held", {31'b0, instr_mem_read}, 32'd1);
                    check32("req_addr_stable", instr_mem_address, req_addr);
                end else if (instr_mem_read && exp_addr.size() != 0) begin
                    req_pc   = exp_addr.pop_front();
                    req_addr = instr_mem_address;
                    check32("req_addr", instr_mem_address, req_pc);
                    pending = 1;
                    cnt     = mem_lat;
                end
                if (pending) begin
                    if (cnt == 0) begin
                        e               = ent_at(req_pc);
                        instr_mem_rdata = e.word;
                        instr_mem_resp  = 1'b1;
                        pending         = 0;
                        if (!flush && !stale) begin
                            acc_now   = 1'b1;
                            acc_entry = e;
                        end
                        stale = 0;
                    end else begin
                        cnt--;
                        if (flush) stale = 1;
                    end
                end
            end
        end
    end

    // ROB-side dequeue driver.
    initial begin
        instr_q_dequeue = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            instr_q_dequeue = deq_force || (deq_en && (exp_q.size() + int'(acc_now) > deq_keep));
        end
    end

    // Monitor: flag checks every cycle, head comparison on every dequeue.
    initial begin
        ent_t       e;
        logic [6:0] got_op;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                continue;
            end
            check32("empty_flag", {31'b0, instr_q_empty}, {31'b0, exp_q.size() == 0});
            check32("full_flag", {31'b0, instr_q_full}, {31'b0, exp_q.size() == 8});
            if (flush) begin
                exp_q.delete();
            end else begin
                if (acc_now) exp_q.push_back(acc_entry);
                if (instr_q_dequeue) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL deq_underflow: dequeue with no expected entry, pci.pc=0x%08h", pci.pc);
                    end else begin
                        e      = exp_q.pop_front();
                        got_op = pci.opcode;
                        if (pci.pc !== e.pc || got_op !== e.opcode || pci.rd !== e.rd ||
                            pci.immediate !== e.imm || pci.br_pred !== e.br_pred ||
                            pci.branch_pc !== e.branch_pc) begin
                            n_fail++;
                            $display("FAIL pci_head: got pc=%h op=%h rd=%0d imm=%h bp=%b bpc=%h expected pc=%h op=%h rd=%0d imm=%h bp=%b bpc=%h",
                                     pci.pc, got_op, pci.rd, pci.immediate, pci.br_pred, pci.branch_pc,
                                     e.pc, e.opcode, e.rd, e.imm, e.br_pred, e.branch_pc);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        logic [6:0] op;
        @(posedge clk);
        #3;
        rst       = 1'b1;
        flush     = 1'b0;
        deq_en    = 0;
        deq_force = 0;
        deq_keep  = 0;
        exp_addr.delete();
        imem.delete();
        #1;
        op = pci.opcode;
        check32("rst_read", {31'b0, instr_mem_read}, 32'd0);
        check32("rst_empty", {31'b0, instr_q_empty}, 32'd1);
        check32("rst_full", {31'b0, instr_q_full}, 32'd0);
        check32("rst_addr", instr_mem_address, 32'h60);
        check32("rst_pci_op", {25'b0, op}, 32'h13);
        check32("rst_pci_pc", pci.pc, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_qsize(input int target, input int budget, input string name);
        int n = 0;
        while (exp_q.size() != target && n < budget) begin
            @(posedge clk);
            n++;
        end
        check32(name, 32'(exp_q.size()), 32'(target));
    endtask

    task automatic wait_addr_drained(input int budget, input string name);
        int n = 0;
        while ((exp_addr.size() != 0 || pending) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check32(name, 32'(exp_addr.size()) + 32'(pending), 32'd0);
    endtask

    initial begin
        ent_t e;
        rst       = 1'b1;
        flush     = 1'b0;
        flush_pc  = 32'h0;

        // Reset, first request timing and bypass of the first response.
        do_reset();
        e.word = 32'h0050_0093; e.opcode = 7'h13; e.rd = 5'd1; e.imm = 32'd5;
        e.br_pred = 1'b0; e.branch_pc = 32'h0; e.pc = 32'h60;
        imem[32'h60] = e;
        push_range(32'h60, 2);
        deq_en = 1;
        @(negedge clk);
        check32("cycle1_read", {31'b0, instr_mem_read}, 32'd0);
        @(negedge clk);
        check32("cycle2_read", {31'b0, instr_mem_read}, 32'd1);
        check32("cycle2_addr", instr_mem_address, 32'h60);
        check32("bypass_pc", pci.pc, 32'h60);
        check32("bypass_rd", {27'b0, pci.rd}, 32'd1);
        @(negedge clk);
        check32("second_addr", instr_mem_address, 32'h64);
        wait_addr_drained(50, "s1_drain");

        // Fill to full with no dequeue, then free one slot.
        do_reset();
        push_range(32'h60, 8);
        wait_qsize(8, 100, "s2_fill");
        #1;
        check32("s2_full", {31'b0, instr_q_full}, 32'd1);
        check32("s2_stall_read", {31'b0, instr_mem_read}, 32'd0);
        exp_addr.push_back(32'h80);
        deq_force = 1;
        @(posedge clk);
        #1;
        deq_force = 0;
        check32("s2_full_clear", {31'b0, instr_q_full}, 32'd0);
        wait_addr_drained(50, "s2_drain");

        // JAL redirect and branch target decode.
        do_reset();
        e.word = 32'h0100_00EF; e.opcode = 7'h6F; e.rd = 5'd1; e.imm = 32'd16;
        e.br_pred = 1'b1; e.branch_pc = 32'h80; e.pc = 32'h70;
        imem[32'h70] = e;
        e.word = 32'hFE00_0CE3; e.opcode = 7'h63; e.rd = 5'd25; e.imm = 32'hFFFF_FFF8;
        e.br_pred = 1'b0; e.branch_pc = 32'h78; e.pc = 32'h80;
        imem[32'h80] = e;
        mem_lat = 1;
        deq_en  = 1;
        push_range(32'h60, 5);
        push_range(32'h80, 3);
        wait_addr_drained(100, "s3_drain");

        // Flush while a request is outstanding: address held, stale data dropped.
        do_reset();
        mem_lat = 0;
        deq_en  = 1;
        push_range(32'h60, 12);
        wait_addr_drained(100, "s4_prefill");
        #1;
        mem_lat = 3;
        exp_addr.push_back(32'h90);
        exp_addr.push_back(32'h200);
        @(posedge clk);
        #1;
        flush    = 1'b1;
        flush_pc = 32'h200;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check32("s4_empty", {31'b0, instr_q_empty}, 32'd1);
        check32("s4_read_held", {31'b0, instr_mem_read}, 32'd1);
        check32("s4_addr_held", instr_mem_address, 32'h90);
        wait_addr_drained(100, "s4_drain");

        // Flush, response and dequeue in the same cycle.
        do_reset();
        mem_lat = 0;
        push_range(32'h60, 2);
        wait_qsize(2, 50, "s5_fill");
        #1;
        flush     = 1'b1;
        flush_pc  = 32'h300;
        deq_force = 1;
        exp_addr.push_back(32'h68);
        exp_addr.push_back(32'h300);
        @(posedge clk);
        #1;
        flush     = 1'b0;
        deq_force = 0;
        check32("s5_empty", {31'b0, instr_q_empty}, 32'd1);
        check32("s5_read", {31'b0, instr_mem_read}, 32'd1);
        check32("s5_addr", instr_mem_address, 32'h300);
        deq_en = 1;
        wait_addr_drained(50, "s5_drain");
        wait_qsize(0, 20, "s5_empty_end");

        // Steady push/pop with three entries resident, across the index wrap.
        do_reset();
        mem_lat  = 1;
        deq_en   = 1;
        deq_keep = 3;
        push_range(32'h60, 23);
        wait_addr_drained(300, "s6_drain");
        deq_keep = 0;
        wait_qsize(0, 50, "s6_empty_end");

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
